setpoint_entry: RTL and testbench
=================================

# setpoint_entry

Multi-motor, multi-digit BCD setpoint editor driven by five debounced push-buttons. It keeps one stored setpoint per motor. In SELECT mode the user picks a motor; in EDIT mode the user edits a working copy digit by digit. On confirm, the block sends the value downstream through a valid/ready command port and writes it back to the per-motor store. It sits between the button debouncers and the motor-control command path, and its display outputs drive the seven-segment driver.

## Interface
- N_MOTORS, 6: number of motors (≥2).
- N_DIGITS, 3: BCD digits per setpoint (≥2); digit 0 is most significant.
- REPEAT_DELAY, 500000: cycles Up/Down must stay held after the press before the first auto-repeat step (≥2).
- REPEAT_PERIOD, 100000: cycles between later auto-repeat steps (≥1).
- MW = max(1, clog2(N_MOTORS)), CW = max(1, clog2(N_DIGITS)): derived local widths.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn_left, btn_right, btn_up, btn_down, btn_enter  in  1 each  debounced, synchronous, active-high levels
- motor  out  MW  selected motor index
- lock  out  1  high whenever state ≠ SELECT
- cursor  out  CW  digit under edit
- disp_value  out  4*N_DIGITS  SELECT: stored value of `motor`; EDIT/COMMIT: working value. Digit 0 is at the MSBs.
- cmd_valid  out  1  command pending
- cmd_ready  in  1  downstream accepts
- cmd_motor  out  MW  motor of pending command
- cmd_value  out  4*N_DIGITS  BCD value of pending command

## Operation
- **Press detection.** A press is `btn & ~btn_q`, where `btn_q` is the registered previous level. `btn_q` resets to 0, so a button already high at reset release counts as a press.
- **Enter priority.** An Enter press takes precedence: Left/Right/Up/Down events in the same cycle are ignored.
- **Opposing buttons.** If Left and Right, or Up and Down, produce events in the same cycle, both are ignored.
- **SELECT state.**
  - Left: `motor` decrements, wrapping 0 → N_MOTORS-1.
  - Right: `motor` increments, wrapping N_MOTORS-1 → 0.
  - Up/Down: ignored.
  - Enter: load working ← store[motor], cursor ← 0, go to EDIT.
- **EDIT state.**
  - Left/Right: move `cursor` with wrap, 0 ↔ N_DIGITS-1.
  - Up: working[cursor] increments, 9 → 0. No carry into other digits.
  - Down: working[cursor] decrements, 0 → 9. No borrow.
  - Enter: go to COMMIT.
- **Auto-repeat (EDIT only, Up/Down only).**
  - A press at cycle t steps at t.
  - If the button is still held, further steps occur at t+REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
  - The repeat counter clears on release, when both Up and Down are high, or on leaving EDIT.
- **COMMIT state.**
  - cmd_valid = 1, cmd_motor = motor, cmd_value = working, all held stable.
  - All buttons are ignored; their `btn_q` registers keep updating.
  - On the cycle where cmd_valid & cmd_ready: store[motor] ← working, cmd_valid → 0, go to SELECT.
- **Stored values.** The store holds only BCD 0–9 per digit and is never modified outside the COMMIT handshake.

## Timing
- **Reset values.**
  - All store entries, working register, motor, cursor, cmd_motor and cmd_value are 0.
  - lock = 0, cmd_valid = 0, state = SELECT, repeat counter = 0.
  - disp_value = 0.
- **Press latency.** A press sampled at clock edge k changes motor/cursor/digits/lock so they are visible after edge k (1-cycle registered latency).
- **Enter to valid.** Enter in EDIT at edge k gives cmd_valid = 1 after edge k.
- **Minimum valid pulse.** With cmd_ready tied high, cmd_valid is high for exactly one cycle. The store write and the return to lock = 0 both take effect after edge k+1.
- **Stalled handshake.** With cmd_ready low, COMMIT is held indefinitely and outputs stay stable.
- **Reset mid-operation.** Asynchronous reset in any state returns all outputs to their reset values immediately, including dropping a pending cmd_valid. Stored setpoints are lost.
- **Output registers.** All outputs come from registers, except disp_value, which is a mux of registered values.

## Test plan
- **Reset then select.** Reset, then 7 Right presses with N_MOTORS = 6 → motor = 1. Then 2 Left presses → motor = 5, lock = 0.
- **Edit and commit.** Motor 2, Enter, cursor 0 Up ×3, Right, Down ×1, Enter, cmd_ready = 1 → one-cycle cmd_valid with cmd_motor = 2, cmd_value = 0x390. After that, lock = 0 and disp_value = 0x390 while motor = 2; motor 3 still shows 0x000.
- **Back-pressure.** Hold cmd_ready = 0 for 20 cycles while toggling every button → cmd_valid stays 1, cmd_value/cmd_motor/cursor unchanged. cmd_ready = 1 → transfer after exactly one cycle.
- **Auto-repeat.** REPEAT_DELAY = 4, REPEAT_PERIOD = 2. Hold Up for 11 cycles from value 8 → steps at t, t+4, t+6, t+8, t+10 → digit sequence 9, 0, 1, 2, 3. Up+Down held together → no steps.
- **Simultaneous events.** Enter + Right in the same cycle in SELECT → EDIT entered, motor unchanged. Left + Right together → no move.
- **Async reset in COMMIT.** Assert rst mid-cycle while cmd_valid = 1 → cmd_valid, lock and motor go to 0 before the next clock, and the store stays 0.

Source files
------------

// File: rtl/setpoint_entry.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | setpoint_entry: button-driven multi-motor BCD setpoint editor with     |
// | per-motor store and valid/ready command output.  Rev 1.0               |
// +------------------------------------------------------------------------+
module setpoint_entry #(
  parameter  int N_MOTORS      = 6,
  parameter  int N_DIGITS      = 3,
  parameter  int REPEAT_DELAY  = 500000,
  parameter  int REPEAT_PERIOD = 100000,
  localparam int MW = (N_MOTORS > 2) ? $clog2(N_MOTORS) : 1,
  localparam int CW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1,
  localparam int DW = 4 * N_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_enter,
  output logic [MW-1:0] motor,
  output logic          lock,
  output logic [CW-1:0] cursor,
  output logic [DW-1:0] disp_value,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [MW-1:0] cmd_motor,
  output logic [DW-1:0] cmd_value
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [4:0]    r_btn_q;
  logic [DW-1:0] r_store [N_MOTORS];
  logic [DW-1:0] r_working;
  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt_first;

  logic [4:0]    w_lvl;
  logic [4:0]    w_press;
  logic          w_enter, w_left, w_right;
  logic          w_one_vert, w_rpt_step;
  logic          w_inc, w_dec;
  logic [RW-1:0] w_rpt_target;
  logic [3:0]    w_digit, w_digit_next;
  int            w_sh;

  assign w_lvl   = {btn_enter, btn_down, btn_up, btn_right, btn_left};
  assign w_press = w_lvl & ~r_btn_q;
  assign w_enter = w_press[4];
  assign w_left  = w_press[0] & ~w_press[1] & ~w_enter;
  assign w_right = w_press[1] & ~w_press[0] & ~w_enter;

  // Repeat counter is nonzero only while a single vertical button is held
  // after having been pressed in EDIT; it counts cycles since the last step.
  assign w_one_vert   = btn_up ^ btn_down;
  assign w_rpt_target = r_rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
  assign w_rpt_step   = w_one_vert && !(w_press[2] || w_press[3]) &&
                        (r_rpt_cnt != '0) && (r_rpt_cnt == w_rpt_target);

  always_comb begin
    logic up_ev, dn_ev;
    up_ev = w_press[2] | (w_rpt_step & btn_up);
    dn_ev = w_press[3] | (w_rpt_step & btn_down);
    w_inc = up_ev & ~dn_ev & ~w_enter;
    w_dec = dn_ev & ~up_ev & ~w_enter;
    w_sh  = 4 * (N_DIGITS - 1 - int'(cursor));
    w_digit = r_working[w_sh +: 4];
    w_digit_next = w_digit;
    if (w_inc)
      w_digit_next = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
    else if (w_dec)
      w_digit_next = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
  end

  assign disp_value = (r_state == S_SELECT) ? r_store[motor] : r_working;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SELECT;
      r_btn_q     <= '0;
      r_working   <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b0;
      motor       <= '0;
      lock        <= 1'b0;
      cursor      <= '0;
      cmd_valid   <= 1'b0;
      cmd_motor   <= '0;
      cmd_value   <= '0;
      for (int i = 0; i < N_MOTORS; i++) r_store[i] <= '0;
    end else begin
      r_btn_q <= w_lvl;
      case (r_state)
        S_SELECT: begin
          r_rpt_cnt <= '0;
          if (w_enter) begin
            r_working <= r_store[motor];
            cursor    <= '0;
            lock      <= 1'b1;
            r_state   <= S_EDIT;
          end else if (w_left) begin
            motor <= (motor == '0) ? MW'(N_MOTORS - 1) : motor - 1'b1;
          end else if (w_right) begin
            motor <= (motor == MW'(N_MOTORS - 1)) ? '0 : motor + 1'b1;
          end
        end
        S_EDIT: begin
          if (w_enter) begin
            cmd_valid <= 1'b1;
            cmd_motor <= motor;
            cmd_value <= r_working;
            r_rpt_cnt <= '0;
            r_state   <= S_COMMIT;
          end else begin
            r_working[w_sh +: 4] <= w_digit_next;
            if (w_left)
              cursor <= (cursor == '0) ? CW'(N_DIGITS - 1) : cursor - 1'b1;
            else if (w_right)
              cursor <= (cursor == CW'(N_DIGITS - 1)) ? '0 : cursor + 1'b1;
            if (!w_one_vert) begin
              r_rpt_cnt <= '0;
            end else if (w_press[2] || w_press[3]) begin
              r_rpt_cnt   <= RW'(1);
              r_rpt_first <= 1'b1;
            end else if (r_rpt_cnt != '0) begin
              if (w_rpt_step) begin
                r_rpt_cnt   <= RW'(1);
                r_rpt_first <= 1'b0;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
              end
            end
          end
        end
        S_COMMIT: begin
          r_rpt_cnt <= '0;
          if (cmd_ready) begin
            r_store[motor] <= r_working;
            cmd_valid      <= 1'b0;
            lock           <= 1'b0;
            r_state        <= S_SELECT;
          end
        end
        default: r_state <= S_SELECT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_setpoint_entry.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_setpoint_entry: directed and random stimulus against a decimal      |
// | reference model of the setpoint editor.  Rev 1.0                       |
// +------------------------------------------------------------------------+
module tb_setpoint_entry;
  localparam int NM = 6, ND = 3, RD = 4, RP = 2;
  localparam int MW = 3, CW = 2, DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    btns = '0;  // {enter, down, up, right, left}
  logic          cmd_ready = 1'b0;
  logic [MW-1:0] motor, cmd_motor;
  logic [CW-1:0] cursor;
  logic [DW-1:0] disp_value, cmd_value;
  logic          lock, cmd_valid;

  setpoint_entry #(.N_MOTORS(NM), .N_DIGITS(ND), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btns[0]), .btn_right(btns[1]), .btn_up(btns[2]), .btn_down(btns[3]),
    .btn_enter(btns[4]),
    .motor(motor), .lock(lock), .cursor(cursor), .disp_value(disp_value),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_motor(cmd_motor), .cmd_value(cmd_value)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: setpoints held as plain decimal integers.
  int         m_store [NM];
  int         m_work, m_motor, m_cursor, m_state, m_age, m_cmd_motor, m_cmd_value;
  bit         m_valid;
  logic [4:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pw(input int i);
    int r = 1;
    for (int k = 0; k < ND - 1 - i; k++) r *= 10;
    return r;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*(ND-1-i) +: 4] = 4'((v / pw(i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NM; i++) m_store[i] = 0;
    m_work = 0; m_motor = 0; m_cursor = 0; m_state = 0; m_age = -1;
    m_cmd_motor = 0; m_cmd_value = 0; m_valid = 0; m_prev = '0;
  endtask

  task automatic model_step();
    logic [4:0] p;
    bit rpt, up, dn;
    int w, d;
    p = btns & ~m_prev;
    m_prev = btns;
    rpt = 0;
    case (m_state)
      0: begin
        m_age = -1;
        if (p[4]) begin
          m_work = m_store[m_motor]; m_cursor = 0; m_state = 1;
        end else if (p[0] ^ p[1]) begin
          m_motor = p[0] ? (m_motor + NM - 1) % NM : (m_motor + 1) % NM;
        end
      end
      1: begin
        if (p[4]) begin
          m_state = 2; m_valid = 1; m_cmd_motor = m_motor; m_cmd_value = m_work; m_age = -1;
        end else begin
          if (btns[2] ^ btns[3]) begin
            if (p[2] | p[3]) m_age = 0;
            else if (m_age >= 0) begin
              m_age++;
              rpt = (m_age == RD) || (m_age > RD && (m_age - RD) % RP == 0);
            end
          end else m_age = -1;
          up = p[2] | (rpt & btns[2]);
          dn = p[3] | (rpt & btns[3]);
          if (up ^ dn) begin
            w = pw(m_cursor);
            d = (m_work / w) % 10;
            if (up) m_work += (d == 9) ? -9 * w : w;
            else    m_work += (d == 0) ?  9 * w : -w;
          end
          if (p[0] ^ p[1]) m_cursor = p[0] ? (m_cursor + ND - 1) % ND : (m_cursor + 1) % ND;
        end
      end
      default: begin
        m_age = -1;
        if (cmd_ready) begin
          m_store[m_motor] = m_work; m_valid = 0; m_state = 0;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_motor"},  32'(motor),      32'(m_motor));
    chk({tag, "_lock"},   32'(lock),       32'(m_state != 0));
    chk({tag, "_cursor"}, 32'(cursor),     32'(m_cursor));
    chk({tag, "_disp"},   32'(disp_value), 32'(to_bcd(m_state == 0 ? m_store[m_motor] : m_work)));
    chk({tag, "_valid"},  32'(cmd_valid),  32'(m_valid));
    chk({tag, "_cmotor"}, 32'(cmd_motor),  32'(m_cmd_motor));
    chk({tag, "_cvalue"}, 32'(cmd_value),  32'(to_bcd(m_cmd_value)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model("cyc");
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1; tick();
    btns[b] = 1'b0; tick();
  endtask

  int rexp [11] = '{9, 9, 9, 9, 0, 0, 1, 1, 2, 2, 3};

  initial begin
    model_reset();
    #1 check_model("reset");
    @(negedge clk) rst = 1'b0;

    // Motor selection with wrap in both directions
    repeat (7) press(1);
    chk("sel_right", 32'(motor), 1);
    repeat (2) press(0);
    chk("sel_left", 32'(motor), 5);
    chk("sel_lock", 32'(lock), 0);

    // Edit motor 2 to 390 and commit with a one-cycle valid
    repeat (3) press(0);
    chk("to_m2", 32'(motor), 2);
    press(4);
    chk("edit_lock", 32'(lock), 1);
    repeat (3) press(2);
    press(1);
    press(3);
    btns[4] = 1'b1; tick();
    chk("commit_valid", 32'(cmd_valid), 1);
    chk("commit_motor", 32'(cmd_motor), 2);
    chk("commit_value", 32'(cmd_value), 32'h390);
    btns[4] = 1'b0; cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    chk("done_valid", 32'(cmd_valid), 0);
    chk("done_lock", 32'(lock), 0);
    chk("done_disp", 32'(disp_value), 32'h390);
    press(1);
    chk("m3_disp", 32'(disp_value), 32'h000);

    // Back-pressure: buttons ignored while COMMIT is stalled
    press(0); press(4); press(4);
    for (int i = 0; i < 20; i++) begin
      btns = 5'($urandom);
      tick();
      chk("bp_valid", 32'(cmd_valid), 1);
      chk("bp_value", 32'(cmd_value), 32'h390);
      chk("bp_cursor", 32'(cursor), 0);
    end
    btns = '0; cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    chk("bp_release", 32'(cmd_valid), 0);
    tick();

    // Auto-repeat on the least significant digit from 8
    press(4);
    press(0);
    chk("cursor_wrap", 32'(cursor), 2);
    repeat (8) press(2);
    chk("pre_rpt", 32'(disp_value), 32'h398);
    btns[2] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("rpt_digit", 32'(disp_value[3:0]), 32'(rexp[k]));
    end
    btns[2] = 1'b0; tick();
    btns[3:2] = 2'b11;
    repeat (10) begin
      tick();
      chk("updown_hold", 32'(disp_value[3:0]), 3);
    end
    btns = '0; tick();
    btns[4] = 1'b1; tick();
    btns[4] = 1'b0; cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    chk("rpt_store", 32'(disp_value), 32'h393);

    // Enter beats Right; Left+Right cancel
    btns = 5'b10010; tick();
    chk("enter_prio_lock", 32'(lock), 1);
    chk("enter_prio_motor", 32'(motor), 2);
    btns = '0; tick();
    press(4);
    cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    btns = 5'b00011; tick();
    chk("lr_cancel", 32'(motor), 2);
    btns = '0; tick();

    // Asynchronous reset while a command is pending
    press(4); press(4);
    chk("pre_rst_valid", 32'(cmd_valid), 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_motor", 32'(motor), 0);
    check_model("rst");
    @(negedge clk) rst = 1'b0;
    press(1); press(1);
    chk("store_lost", 32'(disp_value), 32'h000);

    // Random button levels and handshake timing
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 4 == 0)
        for (int b = 0; b < 5; b++) btns[b] = ($urandom % 3 == 0);
      cmd_ready = 1'($urandom % 2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
